fsm_code_monitor: RTL
=====================

Name: fsm_code_monitor

Overview:
- Downstream checker for the 4-state safe controller whose registered 2-bit output code is the input here.
- Samples the code stream on a strobe and verifies that every step follows the controller's legal transition graph.
- Counts visits per code and errors, and raises an alarm when one code holds for too long.
- Feeds status registers and the debug LEDs; purely observational, with no feedback into the controller.

Parameters:
- CNT_W, 8, width of the per-code visit counters and the error counter; all saturate.
- RUN_W, 8, width of the run-length counter; saturates.
- HOLD_MAX, 16, run length at which hold_alarm asserts. Legal range 2 .. 2^RUN_W-1.

Ports:
- clk  input  1  rising-edge clock, shared with the upstream controller.
- reset  input  1  asynchronous, active-low (0 = reset); deassertion is synchronous to clk upstream.
- code_in  input  2  code from the upstream controller (01, 10, 11, 00).
- sample_en  input  1  strobe; code_in is evaluated only on cycles where this is 1.
- clear  input  1  synchronous clear of all counters, flags and state. Priority: below reset, above sample_en.
- cnt_sel  input  2  selects which visit counter drives cnt_out.
- cnt_out  output  CNT_W  visit count of code cnt_sel. Combinational mux of registers.
- err_count  output  CNT_W  number of illegal transitions, saturating.
- err_flag  output  1  sticky error, set on the first illegal transition.
- last_code  output  2  most recently sampled code.
- run_len  output  RUN_W  consecutive samples of the same code, including the current one; saturating.
- hold_alarm  output  1  registered; equals (run_len >= HOLD_MAX).
- anchored  output  1  1 once a reference sample has been taken.

Behaviour:
- Reset (reset=0, async):
  - All outputs and registers go to 0; last_code=00; state=IDLE.
- Legal transition graph (previous -> next):
  - 01 -> 10
  - 10 -> 10 or 11
  - 11 -> 10 or 00
  - 00 -> 11 or 00
  - Any other pair, including 01->01, is illegal.
- States: IDLE, TRACK, FAULT. The state register is 2-bit, safe-encoded; the unused encoding goes to IDLE, with counters untouched.
- IDLE:
  - On sample_en: last_code<=code_in, run_len<=1, visit[code_in]+=1, anchored<=1, go to TRACK.
  - No legality check is made on this first (anchor) sample.
- TRACK, on sample_en:
  - Update last_code<=code_in and visit[code_in]+=1 (saturating).
  - If code_in==last_code, run_len+=1 (saturating at 2^RUN_W-1); otherwise run_len<=1.
  - If the pair (last_code, code_in) is illegal: err_count+=1 (saturating), err_flag<=1, go to FAULT.
- FAULT:
  - Behaves exactly as TRACK: same checks, counting and updates. err_count keeps incrementing on further illegal pairs.
  - Exits only via clear or reset.
- Without sample_en: all registers hold.
- Latency: every update is visible on the clock edge after the sampling edge (1 cycle). hold_alarm is computed from the next-state run_len, so it asserts in the same cycle run_len reaches HOLD_MAX. It deasserts the cycle run_len resets to 1.
- clear=1:
  - Next edge: all counters, err_flag, anchored, run_len and hold_alarm go to 0; last_code=00; state=IDLE.
  - A sample_en in the same cycle is discarded.
- Saturation: counters stick at all-ones and never wrap. Saturation does not set err_flag.
- Reset mid-operation: immediate asynchronous clear. The first sample after release is an anchor.
- cnt_sel changes affect cnt_out combinationally and do not disturb any state.

Test Plan:
- Reset release, then samples 01,10,11,00,11,10 -> err_count=0, err_flag=0, visit[01]=1, visit[10]=2, visit[11]=2, visit[00]=1, last_code=10, state TRACK.
- Samples 01,10,01 -> the third sample is illegal: err_flag=1, err_count=1, state FAULT. A following 11 (after 01, illegal) gives err_count=2.
- Anchor 10, then 16 more samples of 10 with HOLD_MAX=16:
  - hold_alarm rises on the edge where run_len=16.
  - The next sample, 11, clears run_len to 1 and drops hold_alarm.
- Force visit[00] to 255 (CNT_W=8) via 260 samples of 00 -> cnt_out (cnt_sel=00)=255, no wrap; run_len saturates at 255; err_flag=0.
- clear asserted together with sample_en carrying an illegal code while in FAULT:
  - Next cycle all outputs are 0 and anchored=0; the sample is ignored.
  - The next sample, 11, is accepted as the anchor with no error.
- reset pulled low asynchronously mid-stream, between edges -> outputs are 0 immediately, before the next edge. After release, the first sample (even 01 following 01) causes no error.

Source files
------------

// File: rtl/fsm_code_monitor.sv
// fsm_code_monitor: passive checker for a 4-state controller's 2-bit code stream.
// Checks transition legality, counts visits and errors, and flags over-long holds.
`default_nettype none

module fsm_code_monitor #(
  parameter int CNT_W    = 8,
  parameter int RUN_W    = 8,
  parameter int HOLD_MAX = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [1:0]       code_in,
  input  logic             sample_en,
  input  logic             clear,
  input  logic [1:0]       cnt_sel,
  output logic [CNT_W-1:0] cnt_out,
  output logic [CNT_W-1:0] err_count,
  output logic             err_flag,
  output logic [1:0]       last_code,
  output logic [RUN_W-1:0] run_len,
  output logic             hold_alarm,
  output logic             anchored
);

  localparam logic [RUN_W-1:0] HOLD_MAX_C = RUN_W'(HOLD_MAX);
  localparam logic [RUN_W-1:0] RUN_ONE    = RUN_W'(1);

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    TRACK = 2'b01,
    FAULT = 2'b10
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] visit_q [4];
  logic [CNT_W-1:0] visit_d [4];
  logic [CNT_W-1:0] err_q, err_d;
  logic             flag_q, flag_d;
  logic [1:0]       last_q, last_d;
  logic [RUN_W-1:0] run_q, run_d;
  logic             alarm_q, alarm_d;
  logic             anch_q, anch_d;

  function automatic logic [CNT_W-1:0] inc_cnt(input logic [CNT_W-1:0] v);
    return (v == '1) ? v : v + 1'b1;
  endfunction

  function automatic logic [RUN_W-1:0] inc_run(input logic [RUN_W-1:0] v);
    return (v == '1) ? v : v + 1'b1;
  endfunction

  function automatic logic is_legal(input logic [1:0] prev, input logic [1:0] nxt);
    case (prev)
      2'b01:   return (nxt == 2'b10);
      2'b10:   return (nxt == 2'b10) || (nxt == 2'b11);
      2'b11:   return (nxt == 2'b10) || (nxt == 2'b00);
      default: return (nxt == 2'b11) || (nxt == 2'b00);
    endcase
  endfunction

  always_comb begin
    state_d = state_q;
    visit_d = visit_q;
    err_d   = err_q;
    flag_d  = flag_q;
    last_d  = last_q;
    run_d   = run_q;
    anch_d  = anch_q;

    if (clear) begin
      state_d = IDLE;
      for (int i = 0; i < 4; i++) visit_d[i] = '0;
      err_d   = '0;
      flag_d  = 1'b0;
      last_d  = 2'b00;
      run_d   = '0;
      anch_d  = 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (sample_en) begin
            last_d           = code_in;
            run_d            = RUN_ONE;
            visit_d[code_in] = inc_cnt(visit_q[code_in]);
            anch_d           = 1'b1;
            state_d          = TRACK;
          end
        end
        TRACK, FAULT: begin
          if (sample_en) begin
            last_d           = code_in;
            visit_d[code_in] = inc_cnt(visit_q[code_in]);
            run_d            = (code_in == last_q) ? inc_run(run_q) : RUN_ONE;
            if (!is_legal(last_q, code_in)) begin
              err_d   = inc_cnt(err_q);
              flag_d  = 1'b1;
              state_d = FAULT;
            end
          end
        end
        // Unused encoding recovers to IDLE; statistics are left as they are.
        default: state_d = IDLE;
      endcase
    end

    alarm_d = (run_d >= HOLD_MAX_C);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      for (int i = 0; i < 4; i++) visit_q[i] <= '0;
      err_q   <= '0;
      flag_q  <= 1'b0;
      last_q  <= 2'b00;
      run_q   <= '0;
      alarm_q <= 1'b0;
      anch_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      visit_q <= visit_d;
      err_q   <= err_d;
      flag_q  <= flag_d;
      last_q  <= last_d;
      run_q   <= run_d;
      alarm_q <= alarm_d;
      anch_q  <= anch_d;
    end
  end

  assign cnt_out    = visit_q[cnt_sel];
  assign err_count  = err_q;
  assign err_flag   = flag_q;
  assign last_code  = last_q;
  assign run_len    = run_q;
  assign hold_alarm = alarm_q;
  assign anchored   = anch_q;

endmodule

`default_nettype wire
